// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO data-memory / IO decoder: register offsets,
// timer control bit positions and reset values.
package mmio_pkg;

  localparam logic [4:0] OFF_HEX    = 5'h00;
  localparam logic [4:0] OFF_SW     = 5'h04;
  localparam logic [4:0] OFF_EDGE   = 5'h08;
  localparam logic [4:0] OFF_TCOUNT = 5'h0C;
  localparam logic [4:0] OFF_TCMP   = 5'h10;
  localparam logic [4:0] OFF_TCTRL  = 5'h14;
  localparam logic [4:0] OFF_TSTAT  = 5'h18;

  localparam int TCTRL_EN      = 0;
  localparam int TCTRL_AUTOCLR = 1;
  localparam int TCTRL_IRQEN   = 2;
  localparam int TCTRL_W       = 3;

  localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/mmio_timer.sv
// Free-running 32-bit timer with compare match, optional auto-clear and a
// level interrupt gated by IRQEN.
module mmio_timer
  import mmio_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        wdata_i,
  input  logic               count_we_i,
  input  logic               cmp_we_i,
  input  logic               ctrl_we_i,
  input  logic               stat_we_i,
  output logic [31:0]        count_o,
  output logic [31:0]        cmp_o,
  output logic [TCTRL_W-1:0] ctrl_o,
  output logic               match_o,
  output logic               irq_o
);

  logic [31:0]        count_q, count_d;
  logic [31:0]        cmp_q, cmp_d;
  logic [TCTRL_W-1:0] ctrl_q, ctrl_d;
  logic               match_q, match_d;
  logic               hit;

  assign hit = ctrl_q[TCTRL_EN] && (count_q == cmp_q);

  always_comb begin
    count_d = count_q;
    cmp_d   = cmp_q;
    ctrl_d  = ctrl_q;
    match_d = match_q;

    if (ctrl_q[TCTRL_EN]) begin
      count_d = (hit && ctrl_q[TCTRL_AUTOCLR]) ? 32'd0 : count_q + 32'd1;
    end
    // A software load overrides both increment and auto-clear.
    if (count_we_i) begin
      count_d = wdata_i;
    end

    if (stat_we_i && wdata_i[0]) begin
      match_d = 1'b0;
    end
    if (hit) begin
      match_d = 1'b1;
    end

    if (cmp_we_i) begin
      cmp_d = wdata_i;
    end
    if (ctrl_we_i) begin
      ctrl_d = wdata_i[TCTRL_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 32'd0;
      cmp_q   <= TCMP_RST;
      ctrl_q  <= '0;
      match_q <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      ctrl_q  <= ctrl_d;
      match_q <= match_d;
    end
  end

  assign count_o = count_q;
  assign cmp_o   = cmp_q;
  assign ctrl_o  = ctrl_q;
  assign match_o = match_q;
  assign irq_o   = match_q & ctrl_q[TCTRL_IRQEN];

endmodule

// File: rtl/mmio_bus.sv
// Single-cycle load/store decoder: word-addressed data RAM plus an IO block
// (HEX, synchronised switches, sticky switch edges, timer). Reads are combinational.
module mmio_bus
  import mmio_pkg::*;
#(
  parameter int          DEPTH   = 256,
  parameter logic [31:0] IO_BASE = 32'h0000_0400,
  parameter int          SW_W    = 16,
  parameter int          HEX_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic             memread,
  input  logic [31:0]      addr,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [SW_W-1:0]  sw,
  output logic [HEX_W-1:0] hex,
  output logic             irq
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_LIMIT = 32'(4 * DEPTH);

  logic [31:0]        io_off;
  logic [4:0]         io_word;
  logic               io_hit;
  logic               ram_hit;
  logic [AW-1:0]      ram_idx;
  logic               wr_ok;

  assign wr_ok   = memwrite & ~reset;
  assign ram_hit = addr < RAM_LIMIT;
  assign ram_idx = addr[AW+1:2];
  assign io_off  = addr - IO_BASE;
  assign io_hit  = (addr >= IO_BASE) && (io_off[31:5] == '0);
  assign io_word = io_off[4:0] & 5'b11100;

  logic hex_we, edge_clr, tcount_we, tcmp_we, tctrl_we, tstat_we;
  assign hex_we    = wr_ok & io_hit & (io_word == OFF_HEX);
  assign edge_clr  = wr_ok & io_hit & (io_word == OFF_EDGE);
  assign tcount_we = wr_ok & io_hit & (io_word == OFF_TCOUNT);
  assign tcmp_we   = wr_ok & io_hit & (io_word == OFF_TCMP);
  assign tctrl_we  = wr_ok & io_hit & (io_word == OFF_TCTRL);
  assign tstat_we  = wr_ok & io_hit & (io_word == OFF_TSTAT);

  // RAM contents are deliberately left out of reset.
  logic [31:0] ram_q [DEPTH];
  always_ff @(posedge clk) begin
    if (wr_ok && ram_hit) begin
      ram_q[ram_idx] <= writedata;
    end
  end

  logic [HEX_W-1:0] hex_q, hex_d;
  assign hex_d = hex_we ? writedata[HEX_W-1:0] : hex_q;

  logic [SW_W-1:0] sync1_q, sw_s_q, sw_d_q;
  logic [SW_W-1:0] edge_q, edge_d, edge_set, edge_view;

  assign edge_set = sw_s_q & ~sw_d_q;
  assign edge_d   = (edge_q & ~(edge_clr ? writedata[SW_W-1:0] : '0)) | edge_set;
  // A pending rising edge is already readable before it lands in edge_q.
  assign edge_view = edge_q | edge_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_q   <= '0;
      sync1_q <= '0;
      sw_s_q  <= '0;
      sw_d_q  <= '0;
      edge_q  <= '0;
    end else begin
      hex_q   <= hex_d;
      sync1_q <= sw;
      sw_s_q  <= sync1_q;
      sw_d_q  <= sw_s_q;
      edge_q  <= edge_d;
    end
  end

  logic [31:0]        t_count, t_cmp;
  logic [TCTRL_W-1:0] t_ctrl;
  logic               t_match;

  mmio_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .wdata_i    (writedata),
    .count_we_i (tcount_we),
    .cmp_we_i   (tcmp_we),
    .ctrl_we_i  (tctrl_we),
    .stat_we_i  (tstat_we),
    .count_o    (t_count),
    .cmp_o      (t_cmp),
    .ctrl_o     (t_ctrl),
    .match_o    (t_match),
    .irq_o      (irq)
  );

  always_comb begin
    readdata = '0;
    if (memread) begin
      if (ram_hit) begin
        readdata = ram_q[ram_idx];
      end else if (io_hit) begin
        case (io_word)
          OFF_HEX:    readdata = 32'(hex_q);
          OFF_SW:     readdata = 32'(sw_s_q);
          OFF_EDGE:   readdata = 32'(edge_view);
          OFF_TCOUNT: readdata = t_count;
          OFF_TCMP:   readdata = t_cmp;
          OFF_TCTRL:  readdata = 32'(t_ctrl);
          OFF_TSTAT:  readdata = {31'd0, t_match};
          default:    readdata = '0;
        endcase
      end
    end
  end

  assign hex = hex_q;

endmodule

// File: tb/tb_mmio_bus.sv
// Directed bench for mmio_bus: a register-level model is checked against the DUT
// every negedge, plus literal expectations at the interesting points.
module tb_mmio_bus;

  logic        clk = 1'b0;
  logic        reset, memwrite, memread;
  logic [31:0] addr, writedata, readdata;
  logic [15:0] sw, hex;
  logic        irq;

  always #5 clk = ~clk;

  mmio_bus dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .memread   (memread),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .sw        (sw),
    .hex       (hex),
    .irq       (irq)
  );

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  // Model state: what software should observe at each register.
  logic [31:0] ram_m [int];
  logic [15:0] hex_m;
  logic [15:0] samp [$];   // [0]=oldest sample (sw_d), [1]=sw_s, [2]=newest
  logic [15:0] sticky_m;
  logic [31:0] cnt_m, cmp_m;
  logic [2:0]  ctrl_m;
  logic        match_m;

  logic [31:0] seq [6] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};

  function automatic void model_reset();
    hex_m = 16'h0;
    samp.delete();
    for (int i = 0; i < 3; i++) samp.push_back(16'h0);
    sticky_m = 16'h0;
    cnt_m    = 32'd0;
    cmp_m    = 32'hFFFF_FFFF;
    ctrl_m   = 3'd0;
    match_m  = 1'b0;
  endfunction

  function automatic void model_step();
    logic [31:0] off;
    logic [31:0] nxt;
    logic [15:0] clr;
    bit          io, hitm;
    if (reset) return;
    off  = addr - 32'h400;
    io   = memwrite && (addr >= 32'h400) && (off < 32'd32);
    clr  = 16'h0;
    hitm = ctrl_m[0] && (cnt_m == cmp_m);
    nxt  = cnt_m;
    if (ctrl_m[0]) nxt = (hitm && ctrl_m[1]) ? 32'd0 : cnt_m + 32'd1;
    if (memwrite && addr < 32'd1024) ram_m[int'(addr[9:2])] = writedata;
    if (io) begin
      case (off / 4)
        0: hex_m = writedata[15:0];
        2: clr = writedata[15:0];
        3: nxt = writedata;
        4: cmp_m = writedata;
        5: ctrl_m = writedata[2:0];
        6: if (writedata[0]) match_m = 1'b0;
        default: ;
      endcase
    end
    if (hitm) match_m = 1'b1;
    cnt_m    = nxt;
    sticky_m = (sticky_m & ~clr) | (samp[1] & ~samp[0]);
    void'(samp.pop_front());
    samp.push_back(sw);
  endfunction

  function automatic bit exp_rd(output logic [31:0] v);
    logic [31:0] off;
    v = 32'd0;
    if (!memread) return 1'b1;
    if (addr < 32'd1024) begin
      if (!ram_m.exists(int'(addr[9:2]))) return 1'b0;
      v = ram_m[int'(addr[9:2])];
      return 1'b1;
    end
    off = addr - 32'h400;
    if (addr >= 32'h400 && off < 32'd32) begin
      case (off / 4)
        0: v = {16'h0, hex_m};
        1: v = {16'h0, samp[1]};
        2: v = {16'h0, sticky_m | (samp[1] & ~samp[0])};
        3: v = cnt_m;
        4: v = cmp_m;
        5: v = {29'd0, ctrl_m};
        6: v = {31'd0, match_m};
        default: v = 32'd0;
      endcase
    end
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    logic [31:0] v;
    forever begin
      @(negedge clk);
      if (done) break;
      chk("model_hex", {16'h0, hex}, {16'h0, hex_m});
      chk("model_irq", 32'(irq), 32'(match_m & ctrl_m[2]));
      if (exp_rd(v)) chk("model_readdata", readdata, v);
    end
  end

  task automatic tick(input logic we, input logic [31:0] a, input logic [31:0] wd);
    memwrite  = we;
    memread   = 1'b0;
    addr      = a;
    writedata = wd;
    @(posedge clk);
    model_step();
    $display("tx we=%0d addr=%h wdata=%h reset=%0d sw=%h", we, a, wd, reset, sw);
    #1;
    memwrite = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    memwrite = 1'b0;
    memread  = 1'b1;
    addr     = a;
    #1;
    chk(name, readdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; memwrite = 1'b0; memread = 1'b0;
    addr = 32'd0; writedata = 32'd0; sw = 16'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_hex", {16'h0, hex}, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rd_check("rst_tcmp", 32'h410, 32'hFFFF_FFFF);

    // RAM store/load, memread gating, unmapped address
    tick(1'b1, 32'h10, 32'hDEAD_BEEF);
    rd_check("ram_load", 32'h10, 32'hDEAD_BEEF);
    memread = 1'b0; #1;
    chk("ram_noread", readdata, 32'd0);
    rd_check("unmapped", 32'h2000, 32'd0);
    tick(1'b1, 32'h14, 32'h1111_1111);

    // HEX register and ignored SW write
    tick(1'b1, 32'h400, 32'h0001_ABCD);
    chk("hex_store", {16'h0, hex}, 32'h0000_ABCD);
    rd_check("hex_load", 32'h400, 32'h0000_ABCD);
    tick(1'b1, 32'h404, 32'h0000_1234);
    rd_check("sw_wr_ignored", 32'h404, 32'd0);
    chk("hex_kept", {16'h0, hex}, 32'h0000_ABCD);

    // Switch synchroniser and sticky edges
    sw = 16'h0005;
    tick(1'b0, 32'd0, 32'd0);
    rd_check("sw_1clk", 32'h404, 32'd0);
    tick(1'b0, 32'd0, 32'd0);
    rd_check("sw_2clk", 32'h404, 32'h5);
    rd_check("edge_2clk", 32'h408, 32'h5);
    tick(1'b0, 32'd0, 32'd0);
    tick(1'b1, 32'h408, 32'h1);
    rd_check("edge_w1c", 32'h408, 32'h4);
    sw = 16'h0004;
    repeat (3) tick(1'b0, 32'd0, 32'd0);
    rd_check("edge_fall", 32'h408, 32'h4);
    sw = 16'h0005;
    tick(1'b0, 32'd0, 32'd0);
    tick(1'b0, 32'd0, 32'd0);
    tick(1'b1, 32'h408, 32'h1);
    rd_check("edge_set_beats_clr", 32'h408, 32'h5);
    tick(1'b0, 32'd0, 32'd0);
    rd_check("edge_sticky", 32'h408, 32'h5);
    tick(1'b1, 32'h408, 32'hFFFF);
    rd_check("edge_all_clr", 32'h408, 32'd0);

    // Timer with AUTOCLR and IRQEN
    tick(1'b1, 32'h410, 32'd3);
    tick(1'b1, 32'h414, 32'd7);
    for (int i = 0; i < 6; i++) begin
      rd_check("tcount_seq", 32'h40C, seq[i]);
      chk("irq_seq", 32'(irq), (i >= 4) ? 32'd1 : 32'd0);
      tick(1'b0, 32'd0, 32'd0);
    end
    tick(1'b1, 32'h418, 32'd1);
    rd_check("tstat_w1c", 32'h418, 32'd0);
    chk("irq_cleared", 32'(irq), 32'd0);
    tick(1'b1, 32'h414, 32'd3);
    rd_check("tstat_noirqen", 32'h418, 32'd1);
    chk("irq_masked", 32'(irq), 32'd0);
    tick(1'b0, 32'd0, 32'd0);
    chk("irq_masked2", 32'(irq), 32'd0);

    // Wrap without AUTOCLR, then software load in a match cycle
    tick(1'b1, 32'h414, 32'd0);
    tick(1'b1, 32'h410, 32'd0);
    tick(1'b1, 32'h418, 32'd1);
    tick(1'b1, 32'h40C, 32'hFFFF_FFFE);
    tick(1'b1, 32'h414, 32'd1);
    rd_check("tcount_preload", 32'h40C, 32'hFFFF_FFFE);
    tick(1'b0, 32'd0, 32'd0);
    rd_check("tcount_max", 32'h40C, 32'hFFFF_FFFF);
    tick(1'b0, 32'd0, 32'd0);
    rd_check("tcount_wrap", 32'h40C, 32'd0);
    rd_check("tstat_prematch", 32'h418, 32'd0);
    tick(1'b0, 32'd0, 32'd0);
    rd_check("tcount_noautoclr", 32'h40C, 32'd1);
    rd_check("tstat_match", 32'h418, 32'd1);
    tick(1'b1, 32'h418, 32'd1);
    tick(1'b1, 32'h410, 32'd5);
    tick(1'b0, 32'd0, 32'd0);
    tick(1'b0, 32'd0, 32'd0);
    rd_check("tcount_at_cmp", 32'h40C, 32'd5);
    tick(1'b1, 32'h40C, 32'd100);
    rd_check("tcount_load_wins", 32'h40C, 32'd100);
    rd_check("tstat_load_cycle", 32'h418, 32'd1);
    tick(1'b0, 32'd0, 32'd0);
    rd_check("tcount_after_load", 32'h40C, 32'd101);

    // Asynchronous reset mid-operation
    sw = 16'h0007;
    repeat (3) tick(1'b0, 32'd0, 32'd0);
    rd_check("edge_pre_reset", 32'h408, 32'h2);
    tick(1'b1, 32'h414, 32'd7);
    chk("irq_pre_reset", 32'(irq), 32'd1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_hex", {16'h0, hex}, 32'd0);
    chk("async_irq", 32'(irq), 32'd0);
    rd_check("async_tcount", 32'h40C, 32'd0);
    tick(1'b1, 32'h14, 32'h2222_2222);
    tick(1'b0, 32'd0, 32'd0);
    rd_check("async_edge", 32'h408, 32'd0);
    reset = 1'b0;
    rd_check("post_tcmp", 32'h410, 32'hFFFF_FFFF);
    rd_check("write_in_reset", 32'h14, 32'h1111_1111);
    repeat (3) tick(1'b0, 32'd0, 32'd0);

    done = 1'b1;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
